// File: rtl/secuenciador_dma_if.sv
// rtl/secuenciador_dma_if.sv - peripheral handshake, memory bus and status signals of the DMA sequencer
//
// Purpose: bundles every non-clock signal of secuenciador_dma.
// Modports:
//   master - the sequencer: drives dma_ack, bus_req, mem_addr/rd/wr/dout, ocupado, fin, btc
//   slave  - the environment (peripheral, arbiter, memory): drives dma_req, src_addr,
//            dst_addr, longitud, bus_grant, mem_din
interface secuenciador_dma_if #(
  parameter int CNT_W  = 6,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              dma_req;
  logic              dma_ack;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [CNT_W-1:0]  longitud;
  logic              bus_req;
  logic              bus_grant;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              ocupado;
  logic              fin;
  logic [CNT_W-1:0]  btc;

  modport master (
    input  dma_req, src_addr, dst_addr, longitud, bus_grant, mem_din,
    output dma_ack, bus_req, mem_addr, mem_rd, mem_wr, mem_dout, ocupado, fin, btc
  );

  modport slave (
    output dma_req, src_addr, dst_addr, longitud, bus_grant, mem_din,
    input  dma_ack, bus_req, mem_addr, mem_rd, mem_wr, mem_dout, ocupado, fin, btc
  );
endinterface

// File: rtl/secuenciador_dma.sv
// rtl/secuenciador_dma.sv - single-channel read-then-write DMA burst sequencer
//
// Purpose: copies longitud words (0..2^CNT_W-1) from src_addr to dst_addr, one
// LEER/CAPTURA/ESCRIBIR triple per word, after winning the bus from the CPU.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - secuenciador_dma_if.master (handshake, memory bus, status)
// All outputs are registers decoded from the next state, so they cannot glitch.
module secuenciador_dma #(
  parameter int CNT_W  = 6,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  secuenciador_dma_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ESPERA_BUS, S_LEER, S_CAPTURA, S_ESCRIBIR, S_FIN, S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  btc_q, btc_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              bus_req_q, bus_req_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              fin_q, fin_d;
  logic              ack_q, ack_d;
  logic              ocupado_q, ocupado_d;

  always_comb begin
    state_d = state_q;
    btc_d   = btc_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        btc_d = '0;
        if (bus.dma_req) begin
          src_d   = bus.src_addr;
          dst_d   = bus.dst_addr;
          len_d   = bus.longitud;
          state_d = (bus.longitud == '0) ? S_FIN : S_ESPERA_BUS;
        end
      end
      S_ESPERA_BUS: if (bus.bus_grant) state_d = S_LEER;
      S_LEER:       state_d = S_CAPTURA;
      S_CAPTURA: begin
        // read data arrives the cycle after mem_rd, i.e. during CAPTURA
        data_d  = bus.mem_din;
        state_d = S_ESCRIBIR;
      end
      S_ESCRIBIR: begin
        btc_d = btc_q + 1'b1;
        // grant is only re-examined here, between words, never inside a triple
        if (btc_d == len_q)     state_d = S_FIN;
        else if (bus.bus_grant) state_d = S_LEER;
        else                    state_d = S_ESPERA_BUS;
      end
      S_FIN: state_d = S_ACK;
      S_ACK: begin
        if (!bus.dma_req) begin
          state_d = S_IDLE;
          btc_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are decoded from the state being entered so they register with it
    bus_req_d  = (state_d == S_ESPERA_BUS) || (state_d == S_LEER) ||
                 (state_d == S_CAPTURA)    || (state_d == S_ESCRIBIR);
    mem_rd_d   = (state_d == S_LEER);
    mem_wr_d   = (state_d == S_ESCRIBIR);
    fin_d      = (state_d == S_FIN);
    ack_d      = (state_d == S_FIN) || (state_d == S_ACK);
    ocupado_d  = (state_d != S_IDLE);
    mem_addr_d = '0;
    if ((state_d == S_LEER) || (state_d == S_CAPTURA)) mem_addr_d = src_d + ADDR_W'(btc_d);
    else if (state_d == S_ESCRIBIR)                    mem_addr_d = dst_d + ADDR_W'(btc_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      btc_q      <= '0;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      mem_addr_q <= '0;
      bus_req_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      fin_q      <= 1'b0;
      ack_q      <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      btc_q      <= btc_d;
      len_q      <= len_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      bus_req_q  <= bus_req_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      fin_q      <= fin_d;
      ack_q      <= ack_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign bus.dma_ack  = ack_q;
  assign bus.bus_req  = bus_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_dout = data_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.fin      = fin_q;
  assign bus.btc      = btc_q;

endmodule

// File: tb/tb_secuenciador_dma.sv
// tb/tb_secuenciador_dma.sv - self-checking bench for secuenciador_dma
module tb_secuenciador_dma;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  secuenciador_dma_if #(.CNT_W(6), .ADDR_W(8), .DATA_W(8)) bus_if ();

  secuenciador_dma #(.CNT_W(6), .ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [0:255];
  logic [7:0] exp_rd_addr[$];
  logic [7:0] exp_wr_addr[$];
  logic [7:0] exp_wr_data[$];
  int         wr_seen = 0;
  logic       mon_en = 1'b0;

  logic       cap_rd [0:31];
  logic       cap_wr [0:31];
  logic       cap_fin [0:31];
  logic       cap_breq [0:31];
  logic       cap_ack [0:31];
  logic [7:0] cap_addr [0:31];
  logic [7:0] cap_dout [0:31];
  logic [5:0] cap_btc [0:31];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // memory: read data appears the cycle after mem_rd, writes land in the array
  always @(negedge clk) begin
    if (bus_if.mem_rd) bus_if.mem_din = mem[bus_if.mem_addr];
    if (bus_if.mem_wr) mem[bus_if.mem_addr] = bus_if.mem_dout;
  end

  // transaction model: a copy is the ordered list of reads at src+i and writes
  // of the source word to dst+i; btc counts the writes already completed
  task automatic push_model(input logic [7:0] s, input logic [7:0] d, input logic [5:0] l);
    logic [7:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a = s + 8'(i);
      exp_rd_addr.push_back(a);
      exp_wr_data.push_back(mem[a]);
      a = d + 8'(i);
      exp_wr_addr.push_back(a);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("rd_wr_exclusive", 32'(bus_if.mem_rd && bus_if.mem_wr), 32'd0);
      chk("btc_words_done", 32'(bus_if.btc), bus_if.ocupado ? 32'(wr_seen) : 32'd0);
      if (!bus_if.ocupado) wr_seen = 0;
      if (bus_if.mem_rd || bus_if.mem_wr) chk("strobe_has_bus_req", 32'(bus_if.bus_req), 32'd1);
      if (bus_if.fin) chk("fin_with_ack", 32'(bus_if.dma_ack), 32'd1);
      if (bus_if.mem_rd) begin
        if (exp_rd_addr.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else chk("read_addr", 32'(bus_if.mem_addr), 32'(exp_rd_addr.pop_front()));
      end
      if (bus_if.mem_wr) begin
        if (exp_wr_addr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          chk("write_addr", 32'(bus_if.mem_addr), 32'(exp_wr_addr.pop_front()));
          chk("write_data", 32'(bus_if.mem_dout), 32'(exp_wr_data.pop_front()));
        end
        wr_seen++;
      end
    end
  end

  task automatic run(input int n, input int g0, input int g1);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap_rd[k]   = bus_if.mem_rd;
      cap_wr[k]   = bus_if.mem_wr;
      cap_fin[k]  = bus_if.fin;
      cap_breq[k] = bus_if.bus_req;
      cap_ack[k]  = bus_if.dma_ack;
      cap_addr[k] = bus_if.mem_addr;
      cap_dout[k] = bus_if.mem_dout;
      cap_btc[k]  = bus_if.btc;
      bus_if.bus_grant = !(k >= g0 && k < g1);
    end
  endtask

  task automatic start(input logic [7:0] s, input logic [7:0] d, input logic [5:0] l);
    @(negedge clk);
    bus_if.src_addr = s;
    bus_if.dst_addr = d;
    bus_if.longitud = l;
    bus_if.dma_req  = 1'b1;
    push_model(s, d, l);
  endtask

  task automatic finish_xfer(input string nm);
    chk({nm, "_ack_held"}, 32'(bus_if.dma_ack), 32'd1);
    bus_if.dma_req = 1'b0;
    @(negedge clk);
    chk({nm, "_idle_ocupado"}, 32'(bus_if.ocupado), 32'd0);
    chk({nm, "_idle_ack"}, 32'(bus_if.dma_ack), 32'd0);
    chk({nm, "_idle_btc"}, 32'(bus_if.btc), 32'd0);
    chk({nm, "_model_drained"}, 32'(exp_rd_addr.size() + exp_wr_addr.size()), 32'd0);
  endtask

  function automatic int count_fin(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) c += int'(cap_fin[k]);
    return c;
  endfunction

  function automatic int count_activity(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) c += int'(cap_rd[k]) + int'(cap_wr[k]) + int'(cap_breq[k]);
    return c;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[8'h10] = 8'hA5;
    bus_if.dma_req   = 1'b1;
    bus_if.src_addr  = 8'h10;
    bus_if.dst_addr  = 8'h80;
    bus_if.longitud  = 6'd1;
    bus_if.bus_grant = 1'b1;
    bus_if.mem_din   = 8'h00;

    // reset held with a pending request: everything quiet
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", {bus_if.bus_req, bus_if.mem_rd, bus_if.mem_wr, bus_if.dma_ack,
                          bus_if.ocupado, bus_if.fin}, 32'd0);
      chk("rst_btc", 32'(bus_if.btc), 32'd0);
      chk("rst_addr_dout", {bus_if.mem_addr, bus_if.mem_dout}, 32'd0);
    end
    mon_en = 1'b1;

    // release: single-word copy 0x10 -> 0x80 starts from IDLE
    rst_n = 1'b1;
    push_model(8'h10, 8'h80, 6'd1);
    run(6, 99, 99);
    chk("w1_idle_first", 32'(cap_breq[1] && !cap_rd[1]), 32'd1);
    chk("w1_rd_c2", {cap_rd[2], cap_addr[2]}, {1'b1, 8'h10});
    chk("w1_wr_c4", {cap_wr[4], cap_addr[4], cap_dout[4]}, {1'b1, 8'h80, 8'hA5});
    chk("w1_fin_c5", {cap_fin[5], 2'(cap_btc[5])}, {1'b1, 2'd1});
    chk("w1_fin_count", 32'(count_fin(6)), 32'd1);
    chk("w1_mem_written", 32'(mem[8'h80]), 32'hA5);
    finish_xfer("w1");

    // three-word burst, grant held
    start(8'h10, 8'h80, 6'd3);
    run(14, 99, 99);
    chk("b3_rd2", {cap_rd[2], cap_addr[2]}, {1'b1, 8'h10});
    chk("b3_rd5", {cap_rd[5], cap_addr[5]}, {1'b1, 8'h11});
    chk("b3_rd8", {cap_rd[8], cap_addr[8]}, {1'b1, 8'h12});
    chk("b3_wr4", {cap_wr[4], cap_addr[4]}, {1'b1, 8'h80});
    chk("b3_wr7", {cap_wr[7], cap_addr[7]}, {1'b1, 8'h81});
    chk("b3_wr10", {cap_wr[10], cap_addr[10]}, {1'b1, 8'h82});
    chk("b3_fin11", 32'(cap_fin[11]), 32'd1);
    chk("b3_fin_count", 32'(count_fin(14)), 32'd1);
    chk("b3_ack_held", {cap_ack[11], cap_ack[12], cap_ack[13], cap_ack[14]}, 32'hF);
    chk("b3_btc_final", 32'(cap_btc[14]), 32'd3);
    finish_xfer("b3");

    // grant lost during word 2 CAPTURA (cycle 6) for 5 cycles
    start(8'h10, 8'h80, 6'd4);
    run(20, 6, 11);
    chk("gl_wr2_completes", {cap_wr[7], cap_addr[7]}, {1'b1, 8'h81});
    chk("gl_wait_breq", {cap_breq[8], cap_breq[9], cap_breq[10], cap_breq[11]}, 32'hF);
    chk("gl_wait_no_rd", {cap_rd[8], cap_rd[9], cap_rd[10], cap_rd[11]}, 32'h0);
    chk("gl_rd3_c12", {cap_rd[12], cap_addr[12]}, {1'b1, 8'h12});
    chk("gl_fin18", 32'(cap_fin[18]), 32'd1);
    chk("gl_fin_count", 32'(count_fin(20)), 32'd1);
    finish_xfer("gl");

    // zero length: done without touching the bus
    start(8'h20, 8'h90, 6'd0);
    run(5, 99, 99);
    chk("z_fin1", 32'(cap_fin[1]), 32'd1);
    chk("z_fin_count", 32'(count_fin(5)), 32'd1);
    chk("z_no_bus_activity", 32'(count_activity(5)), 32'd0);
    finish_xfer("z");

    // source address wraps past 0xFF
    start(8'hFE, 8'h40, 6'd3);
    run(12, 99, 99);
    chk("wr_rd2", {cap_rd[2], cap_addr[2]}, {1'b1, 8'hFE});
    chk("wr_rd5", {cap_rd[5], cap_addr[5]}, {1'b1, 8'hFF});
    chk("wr_rd8", {cap_rd[8], cap_addr[8]}, {1'b1, 8'h00});
    chk("wr_fin11", 32'(cap_fin[11]), 32'd1);
    chk("wr_data_0x42", 32'(mem[8'h42]), 32'(8'h00 ^ 8'h3C));
    finish_xfer("wr");

    // reset during word 2 ESCRIBIR
    start(8'h10, 8'h80, 6'd4);
    run(7, 99, 99);
    chk("ra_in_escribir", {cap_wr[7], cap_addr[7]}, {1'b1, 8'h81});
    rst_n = 1'b0;
    #1;
    chk("ra_drop", {bus_if.mem_wr, bus_if.bus_req, bus_if.ocupado, bus_if.fin}, 32'd0);
    chk("ra_btc", 32'(bus_if.btc), 32'd0);
    bus_if.dma_req = 1'b0;
    exp_rd_addr.delete();
    exp_wr_addr.delete();
    exp_wr_data.delete();
    run(3, 99, 99);
    chk("ra_no_fin", 32'(count_fin(3)), 32'd0);
    rst_n = 1'b1;
    run(3, 99, 99);
    chk("ra_stays_idle", 32'(count_activity(3) + count_fin(3)), 32'd0);
    chk("ra_ocupado", 32'(bus_if.ocupado), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
